// File: rtl/prog_loader_if.sv
// Program-loader bus bundle: image stream in, memory write port out,
// plus CPU hand-off and status. clk and reset stay outside the bundle.
interface prog_loader_if;
  logic        start;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic [15:0] maxmem;
  logic [15:0] benchmar;
  logic [15:0] benchmdr;
  logic        benchmrw;
  logic        membench;
  logic        cpu_reset;
  logic        done;
  logic        overflow;
  logic [15:0] word_count;

  // Loader side of the bundle.
  modport master (
    input  start, in_valid, in_data, in_last, maxmem,
    output in_ready, benchmar, benchmdr, benchmrw, membench,
           cpu_reset, done, overflow, word_count
  );

  // Environment side: image source, memory and CPU.
  modport slave (
    output start, in_valid, in_data, in_last, maxmem,
    input  in_ready, benchmar, benchmdr, benchmrw, membench,
           cpu_reset, done, overflow, word_count
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: streams an image into memory starting at START_ADDR,
// then waits SETTLE_CYCLES cycles before releasing the CPU from reset.
// Each write is registered, so it reaches memory on the edge after its
// accept. Running past maxmem stops the load in ERR with the CPU held.
module prog_loader #(
  parameter logic [15:0] START_ADDR    = 16'd0,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  prog_loader_if.master bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOAD   = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] RUN    = 3'd3;
  localparam logic [2:0] ERR    = 3'd4;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [2:0]  state_reg;
  logic [3:0]  settle_cnt_reg;
  logic [16:0] addr_reg;     // one bit wider so it never wraps past 16'hFFFF
  logic [15:0] mar_reg;
  logic [15:0] mdr_reg;
  logic        mrw_reg;
  logic [15:0] wc_reg;
  logic        ovf_reg;

  logic accept;
  logic fits;

  assign accept = (state_reg == LOAD) && bus.in_valid;
  assign fits   = addr_reg <= {1'b0, bus.maxmem};

  // State sequencing; RUN and ERR are only left through reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      settle_cnt_reg <= 4'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) state_reg <= LOAD;
        end
        LOAD: begin
          if (accept) begin
            if (!fits) begin
              state_reg <= ERR;
            end else if (bus.in_last) begin
              state_reg      <= SETTLE;
              settle_cnt_reg <= 4'd0;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt_reg == SETTLE_LAST) state_reg <= RUN;
          else settle_cnt_reg <= settle_cnt_reg + 4'd1;
        end
        RUN:     state_reg <= RUN;
        ERR:     state_reg <= ERR;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Write port, address counter and status; write enable is a one-cycle
  // pulse per accepted word so nothing is ever written twice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg <= {1'b0, START_ADDR};
      mar_reg  <= START_ADDR;
      mdr_reg  <= 16'd0;
      mrw_reg  <= 1'b0;
      wc_reg   <= 16'd0;
      ovf_reg  <= 1'b0;
    end else begin
      mrw_reg <= 1'b0;
      if (state_reg == IDLE && bus.start) begin
        addr_reg <= {1'b0, START_ADDR};
        wc_reg   <= 16'd0;
      end
      if (accept && fits) begin
        mar_reg  <= addr_reg[15:0];
        mdr_reg  <= bus.in_data;
        mrw_reg  <= 1'b1;
        addr_reg <= addr_reg + 17'd1;
        wc_reg   <= wc_reg + 16'd1;
      end
      if (accept && !fits) ovf_reg <= 1'b1;
    end
  end

  assign bus.in_ready   = (state_reg == LOAD);
  assign bus.membench   = (state_reg != RUN);
  assign bus.cpu_reset  = (state_reg != RUN);
  assign bus.done       = (state_reg == RUN);
  assign bus.benchmar   = mar_reg;
  assign bus.benchmdr   = mdr_reg;
  assign bus.benchmrw   = mrw_reg;
  assign bus.overflow   = ovf_reg;
  assign bus.word_count = wc_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a table of per-cycle vectors for
// the basic load, then hand-written sequences for stalls, overflow, the
// maxmem boundary and reset in the middle of a load.
module tb_prog_loader;

  logic clk;
  logic reset;
  logic clr_log;
  prog_loader_if bus ();

  prog_loader #(.START_ADDR(16'd0), .SETTLE_CYCLES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model plus a log of write addresses.
  logic [15:0] mem    [0:15];
  logic [15:0] wr_log [0:15];
  int          wr_count = 0;

  always @(posedge clk) begin
    if (clr_log) begin
      wr_count <= 0;
    end else if (bus.benchmrw === 1'b1) begin
      mem[bus.benchmar[3:0]] <= bus.benchmdr;
      wr_log[wr_count[3:0]]  <= bus.benchmar;
      wr_count               <= wr_count + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic v, input logic [15:0] d, input logic l);
    bus.start    = s;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    reset   = 1'b1;
    clr_log = 1'b1;
    step();
    step();
    reset   = 1'b0;
    clr_log = 1'b0;
  endtask

  typedef struct {
    logic        start;
    logic        valid;
    logic [15:0] data;
    logic        last;
    logic        mrw;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic [15:0] wc;
    logic        rdy;
    logic        crst;
    logic        done;
    logic        ovf;
  } vec_t;

  vec_t vecs [0:7];
  int   k;

  initial begin
    // start, valid, data, last | mrw, mar, mdr, wc, rdy, crst, done, ovf
    vecs[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd0, 16'h0000, 16'd0, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 16'hB010, 1'b0, 1'b1, 16'd0, 16'hB010, 16'd1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 16'hEA00, 1'b0, 1'b1, 16'd1, 16'hEA00, 16'd2, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 16'hB000, 1'b1, 1'b1, 16'd2, 16'hB000, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd2, 16'hB000, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd2, 16'hB000, 16'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd2, 16'hB000, 16'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 16'd2, 16'hB000, 16'd3, 1'b0, 1'b0, 1'b1, 1'b0};

    reset   = 1'b0;
    clr_log = 1'b0;
    bus.maxmem = 16'd4095;
    drive(1'b0, 1'b0, 16'h0, 1'b0);

    // Reset takes effect before any clock edge.
    #2 reset = 1'b1;
    #1;
    chk("rst_in_ready",  {15'd0, bus.in_ready},  16'd0);
    chk("rst_benchmar",  bus.benchmar,           16'd0);
    chk("rst_benchmdr",  bus.benchmdr,           16'd0);
    chk("rst_benchmrw",  {15'd0, bus.benchmrw},  16'd0);
    chk("rst_membench",  {15'd0, bus.membench},  16'd1);
    chk("rst_cpu_reset", {15'd0, bus.cpu_reset}, 16'd1);
    chk("rst_done",      {15'd0, bus.done},      16'd0);
    chk("rst_overflow",  {15'd0, bus.overflow},  16'd0);
    chk("rst_wc",        bus.word_count,         16'd0);
    step();
    reset = 1'b0;

    // Stays idle without start.
    step();
    chk("idle_in_ready", {15'd0, bus.in_ready}, 16'd0);
    $display("reset/idle checks done");

    // Basic load, table driven (includes spurious starts in LOAD and RUN).
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].start, vecs[i].valid, vecs[i].data, vecs[i].last);
      step();
      $display("vec %0d start=%b valid=%b data=%h last=%b -> mrw=%b mar=%h mdr=%h wc=%0d crst=%b done=%b",
               i, vecs[i].start, vecs[i].valid, vecs[i].data, vecs[i].last,
               bus.benchmrw, bus.benchmar, bus.benchmdr, bus.word_count, bus.cpu_reset, bus.done);
      chk($sformatf("v%0d_mrw", i),  {15'd0, bus.benchmrw},  {15'd0, vecs[i].mrw});
      chk($sformatf("v%0d_mar", i),  bus.benchmar,           vecs[i].mar);
      chk($sformatf("v%0d_mdr", i),  bus.benchmdr,           vecs[i].mdr);
      chk($sformatf("v%0d_wc", i),   bus.word_count,         vecs[i].wc);
      chk($sformatf("v%0d_rdy", i),  {15'd0, bus.in_ready},  {15'd0, vecs[i].rdy});
      chk($sformatf("v%0d_crst", i), {15'd0, bus.cpu_reset}, {15'd0, vecs[i].crst});
      chk($sformatf("v%0d_mb", i),   {15'd0, bus.membench},  {15'd0, vecs[i].crst});
      chk($sformatf("v%0d_done", i), {15'd0, bus.done},      {15'd0, vecs[i].done});
      chk($sformatf("v%0d_ovf", i),  {15'd0, bus.overflow},  {15'd0, vecs[i].ovf});
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    chk("basic_wr_count", 16'(wr_count), 16'd3);
    chk("basic_mem0", mem[0], 16'hB010);
    chk("basic_mem1", mem[1], 16'hEA00);
    chk("basic_mem2", mem[2], 16'hB000);

    // Stalls: valid pattern 1,0,0,1,1(last).
    do_reset();
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    step();
    k = 0;
    for (int i = 0; i < 5; i++) begin
      logic v;
      v = (i == 0 || i == 3 || i == 4);
      drive(1'b0, v, 16'hC000 + 16'(i), (i == 4));
      step();
      $display("stall cyc %0d valid=%b -> mrw=%b mar=%h wc=%0d", i, v, bus.benchmrw, bus.benchmar, bus.word_count);
      chk($sformatf("stall%0d_mrw", i), {15'd0, bus.benchmrw}, {15'd0, v});
      if (v) begin
        chk($sformatf("stall%0d_mar", i), bus.benchmar, 16'(k));
        chk($sformatf("stall%0d_mdr", i), bus.benchmdr, 16'hC000 + 16'(i));
        k++;
      end
      chk($sformatf("stall%0d_wc", i), bus.word_count, 16'(k));
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    step();
    chk("stall_wr_count", 16'(wr_count), 16'd3);
    chk("stall_addr0", wr_log[0], 16'd0);
    chk("stall_addr1", wr_log[1], 16'd1);
    chk("stall_addr2", wr_log[2], 16'd2);
    step();
    chk("stall_done", {15'd0, bus.done}, 16'd1);

    // Overflow: maxmem=3, five words, last on the fifth.
    bus.maxmem = 16'd3;
    do_reset();
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b1, 16'hA0 + 16'(i), (i == 4));
      step();
      $display("ovf word %0d -> mrw=%b mar=%h wc=%0d ovf=%b", i, bus.benchmrw, bus.benchmar, bus.word_count, bus.overflow);
      if (i < 4) begin
        chk($sformatf("ovf%0d_mrw", i), {15'd0, bus.benchmrw}, 16'd1);
        chk($sformatf("ovf%0d_mar", i), bus.benchmar, 16'(i));
      end else begin
        chk("ovf4_mrw",  {15'd0, bus.benchmrw}, 16'd0);
        chk("ovf4_flag", {15'd0, bus.overflow}, 16'd1);
        chk("ovf4_wc",   bus.word_count,        16'd4);
        chk("ovf4_rdy",  {15'd0, bus.in_ready}, 16'd0);
        chk("ovf4_mar",  bus.benchmar,          16'd3);
        chk("ovf4_mdr",  bus.benchmdr,          16'hA3);
      end
    end
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) step();
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    chk("ovf_crst", {15'd0, bus.cpu_reset}, 16'd1);
    chk("ovf_mb",   {15'd0, bus.membench},  16'd1);
    chk("ovf_done", {15'd0, bus.done},      16'd0);
    chk("ovf_sticky", {15'd0, bus.overflow}, 16'd1);
    chk("ovf_wr_count", 16'(wr_count), 16'd4);
    chk("ovf_mem3", mem[3], 16'hA3);

    // Boundary: maxmem=3, exactly four words.
    do_reset();
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 16'h50 + 16'(i), (i == 3));
      step();
      $display("bnd word %0d -> mrw=%b mar=%h wc=%0d", i, bus.benchmrw, bus.benchmar, bus.word_count);
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    step();
    chk("bnd_settle_crst", {15'd0, bus.cpu_reset}, 16'd1);
    step();
    chk("bnd_done", {15'd0, bus.done},      16'd1);
    chk("bnd_ovf",  {15'd0, bus.overflow},  16'd0);
    chk("bnd_wc",   bus.word_count,         16'd4);
    chk("bnd_wr_count", 16'(wr_count), 16'd4);

    // Reset mid-load after two accepted words.
    bus.maxmem = 16'd4095;
    do_reset();
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    step();
    drive(1'b0, 1'b1, 16'hD1, 1'b0);
    step();
    drive(1'b0, 1'b1, 16'hD2, 1'b0);
    step();
    chk("mid_pre_mrw", {15'd0, bus.benchmrw}, 16'd1);
    #2 reset = 1'b1;
    #1;
    $display("mid-load reset -> mrw=%b wc=%0d rdy=%b", bus.benchmrw, bus.word_count, bus.in_ready);
    chk("mid_mrw", {15'd0, bus.benchmrw}, 16'd0);
    chk("mid_wc",  bus.word_count,        16'd0);
    chk("mid_rdy", {15'd0, bus.in_ready}, 16'd0);
    chk("mid_mar", bus.benchmar,          16'd0);
    step();
    reset = 1'b0;
    chk("mid_wr_count", 16'(wr_count), 16'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mid_idle%0d_rdy", i), {15'd0, bus.in_ready}, 16'd0);
      chk($sformatf("mid_idle%0d_mrw", i), {15'd0, bus.benchmrw}, 16'd0);
    end
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    step();
    drive(1'b0, 1'b1, 16'hD9, 1'b1);
    step();
    $display("reload word -> mrw=%b mar=%h mdr=%h wc=%0d", bus.benchmrw, bus.benchmar, bus.benchmdr, bus.word_count);
    chk("reload_mrw", {15'd0, bus.benchmrw}, 16'd1);
    chk("reload_mar", bus.benchmar,          16'd0);
    chk("reload_mdr", bus.benchmdr,          16'hD9);
    chk("reload_wc",  bus.word_count,        16'd1);
    drive(1'b0, 1'b0, 16'h0, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
